// File: rtl/adxl_spi_responder_pkg.sv
// Shared constants, state encoding and address predicates for the ADXL345-style SPI responder.
package adxl_spi_responder_pkg;

  localparam logic [7:0] DEVID_DEFAULT = 8'hE5;
  localparam logic [7:0] BW_RATE_RESET = 8'h0A;

  localparam int CMD_RW_BIT  = 7;
  localparam int CMD_MB_BIT  = 6;
  localparam int MEASURE_BIT = 3;
  localparam int DRDY_BIT    = 7;

  localparam logic [5:0] DEVID_ADDR     = 6'h00;
  localparam logic [5:0] THRESH_TAP     = 6'h1D;
  localparam logic [5:0] THRESH_ACT     = 6'h24;
  localparam logic [5:0] THRESH_INACT   = 6'h25;
  localparam logic [5:0] TIME_INACT     = 6'h26;
  localparam logic [5:0] ACT_INACT_CTL  = 6'h27;
  localparam logic [5:0] THRESH_FF      = 6'h28;
  localparam logic [5:0] TIME_FF        = 6'h29;
  localparam logic [5:0] TAP_AXES       = 6'h2A;
  localparam logic [5:0] BW_RATE        = 6'h2C;
  localparam logic [5:0] POWER_CONTROL  = 6'h2D;
  localparam logic [5:0] INT_ENABLE     = 6'h2E;
  localparam logic [5:0] INT_MAP        = 6'h2F;
  localparam logic [5:0] INT_SOURCE     = 6'h30;
  localparam logic [5:0] DATA_FORMAT    = 6'h31;
  localparam logic [5:0] X_LB           = 6'h32;
  localparam logic [5:0] X_HB           = 6'h33;
  localparam logic [5:0] Y_LB           = 6'h34;
  localparam logic [5:0] Y_HB           = 6'h35;
  localparam logic [5:0] Z_LB           = 6'h36;
  localparam logic [5:0] Z_HB           = 6'h37;
  localparam logic [5:0] FIFO_CTL       = 6'h38;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } spi_state_e;

  // Host-configurable registers; everything else ignores SPI writes.
  function automatic logic is_writable(input logic [5:0] addr);
    return ((addr >= THRESH_TAP) && (addr <= TAP_AXES)) ||
           ((addr >= BW_RATE) && (addr <= INT_MAP)) ||
           (addr == DATA_FORMAT) || (addr == FIFO_CTL);
  endfunction

  // Sample data bytes; reading any of them acknowledges data-ready.
  function automatic logic is_sample_addr(input logic [5:0] addr);
    return (addr >= X_LB) && (addr <= Z_HB);
  endfunction

endpackage

// File: rtl/adxl_spi_responder_sync_edge.sv
// N-stage synchroniser for one asynchronous SPI pin, with level and edge pulses.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic iSPI_CLK,
  input  logic iRSTN,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Shift the pin through the synchroniser chain and keep the previous synchronised level.
  always_ff @(posedge iSPI_CLK or negedge iRSTN) begin
    if (!iRSTN) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign sync_o = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/adxl_spi_responder.sv
// SPI mode-3 slave that emulates the ADXL345 register interface for closed-loop testing.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | CSN high or transaction aborted; SDO released
// ST_CMD  | shifting in the command byte (R/W, MB, address)
// ST_DATA | data bytes: write shifts in and commits, read shifts rdata out
module adxl_spi_responder
  import adxl_spi_responder_pkg::*;
#(
  parameter logic [7:0] DEVID       = DEVID_DEFAULT,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        iRSTN,
  input  logic        iSPI_CLK,
  input  logic        iSCLK,
  input  logic        iCSN,
  input  logic        iSDI,
  output logic        oSDO,
  output logic        oSDO_OE,
  input  logic [15:0] iSAMPLE_X,
  input  logic [15:0] iSAMPLE_Y,
  input  logic [15:0] iSAMPLE_Z,
  input  logic        iSAMPLE_VALID,
  output logic        oREG_WR,
  output logic [5:0]  oREG_ADDR,
  output logic [7:0]  oREG_WDATA,
  output logic        oMEASURE,
  output logic        oDRDY
);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic csn_lvl, csn_rise, csn_fall;
  logic sdi_lvl, sdi_rise, sdi_fall;
  logic unused_sync;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sclk (
    .iSPI_CLK(iSPI_CLK), .iRSTN(iRSTN), .async_i(iSCLK),
    .sync_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csn (
    .iSPI_CLK(iSPI_CLK), .iRSTN(iRSTN), .async_i(iCSN),
    .sync_o(csn_lvl), .rise_o(csn_rise), .fall_o(csn_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
    .iSPI_CLK(iSPI_CLK), .iRSTN(iRSTN), .async_i(iSDI),
    .sync_o(sdi_lvl), .rise_o(sdi_rise), .fall_o(sdi_fall)
  );

  assign unused_sync = ^{sclk_lvl, sdi_rise, sdi_fall};

  spi_state_e  state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  shift_q, shift_d;
  logic        rw_q, rw_d;
  logic        mb_q, mb_d;
  logic [5:0]  addr_q, addr_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [7:0]  rx_byte;
  logic [5:0]  next_addr;
  logic [5:0]  fetch_addr;
  logic [7:0]  fetch_data;
  logic        commit_wr;
  logic        tx_start;

  logic [7:0]  regs_q [64];
  logic        wr_q;
  logic [5:0]  wr_addr_q;
  logic [7:0]  wr_data_q;
  logic        sdo_q;
  logic [7:0]  tx_q;

  logic [15:0] smp_x_q, smp_y_q, smp_z_q;
  logic [15:0] pend_x_q, pend_y_q, pend_z_q;
  logic        pend_valid_q;
  logic        drdy_q;
  logic        data_read_q;
  logic        sample_accept;

  assign rx_byte       = {shift_q, sdi_lvl};
  assign next_addr     = mb_q ? (addr_q + 6'd1) : addr_q;
  assign fetch_addr    = (state_q == ST_CMD) ? rx_byte[5:0] : next_addr;
  assign tx_start      = (state_q == ST_DATA) && rw_q && sclk_fall && (bit_cnt_q == 3'd0) && !csn_rise;
  assign sample_accept = iSAMPLE_VALID && regs_q[POWER_CONTROL][MEASURE_BIT];

  // Read map: live INT_SOURCE and sample bytes override the register array.
  always_comb begin
    fetch_data = regs_q[fetch_addr];
    case (fetch_addr)
      INT_SOURCE: fetch_data = {drdy_q, 7'b0};
      X_LB:       fetch_data = smp_x_q[7:0];
      X_HB:       fetch_data = smp_x_q[15:8];
      Y_LB:       fetch_data = smp_y_q[7:0];
      Y_HB:       fetch_data = smp_y_q[15:8];
      Z_LB:       fetch_data = smp_z_q[7:0];
      Z_HB:       fetch_data = smp_z_q[15:8];
      default:    ;
    endcase
  end

  // Next-state logic: byte framing, command decode, read prefetch and write commit.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    rw_d      = rw_q;
    mb_d      = mb_q;
    addr_d    = addr_q;
    rdata_d   = rdata_q;
    commit_wr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (csn_fall) begin
          state_d   = ST_CMD;
          bit_cnt_d = 3'd0;
        end
      end
      ST_CMD: begin
        if (sclk_rise) begin
          shift_d   = rx_byte[6:0];
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rw_d    = rx_byte[CMD_RW_BIT];
            mb_d    = rx_byte[CMD_MB_BIT];
            addr_d  = rx_byte[5:0];
            state_d = ST_DATA;
            if (rx_byte[CMD_RW_BIT]) rdata_d = fetch_data;
          end
        end
      end
      ST_DATA: begin
        if (sclk_rise) begin
          shift_d   = rx_byte[6:0];
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            addr_d = next_addr;
            if (rw_q) rdata_d = fetch_data;
            else if (is_writable(addr_q)) commit_wr = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // CSN rise aborts whatever is in flight, including a byte completing in the same cycle.
    if (csn_rise) begin
      state_d   = ST_IDLE;
      commit_wr = 1'b0;
    end
  end

  // FSM and shift-path registers.
  always_ff @(posedge iSPI_CLK or negedge iRSTN) begin
    if (!iRSTN) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 7'd0;
      rw_q      <= 1'b0;
      mb_q      <= 1'b0;
      addr_q    <= 6'd0;
      rdata_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      rw_q      <= rw_d;
      mb_q      <= mb_d;
      addr_q    <= addr_d;
      rdata_q   <= rdata_d;
    end
  end

  // Register array with power-on defaults; only writable addresses ever change.
  always_ff @(posedge iSPI_CLK or negedge iRSTN) begin
    if (!iRSTN) begin
      for (int i = 0; i < 64; i++) regs_q[i] <= 8'h00;
      regs_q[DEVID_ADDR] <= DEVID;
      regs_q[BW_RATE]    <= BW_RATE_RESET;
    end else if (commit_wr) begin
      regs_q[addr_q] <= rx_byte;
    end
  end

  // Host-side write notification, aligned with the register update.
  always_ff @(posedge iSPI_CLK or negedge iRSTN) begin
    if (!iRSTN) begin
      wr_q      <= 1'b0;
      wr_addr_q <= 6'd0;
      wr_data_q <= 8'd0;
    end else begin
      wr_q <= commit_wr;
      if (commit_wr) begin
        wr_addr_q <= addr_q;
        wr_data_q <= rx_byte;
      end
    end
  end

  // SDO shifter: load a fresh byte on its first falling edge, then shift left.
  always_ff @(posedge iSPI_CLK or negedge iRSTN) begin
    if (!iRSTN) begin
      sdo_q <= 1'b0;
      tx_q  <= 8'd0;
    end else if (csn_rise) begin
      sdo_q <= 1'b0;
    end else if ((state_q == ST_DATA) && rw_q && sclk_fall) begin
      if (bit_cnt_q == 3'd0) {sdo_q, tx_q} <= {rdata_q, 1'b0};
      else                   {sdo_q, tx_q} <= {tx_q, 1'b0};
    end
  end

  // Sample capture: direct load while deselected, buffered until CSN rise otherwise.
  always_ff @(posedge iSPI_CLK or negedge iRSTN) begin
    if (!iRSTN) begin
      smp_x_q      <= 16'd0;
      smp_y_q      <= 16'd0;
      smp_z_q      <= 16'd0;
      pend_x_q     <= 16'd0;
      pend_y_q     <= 16'd0;
      pend_z_q     <= 16'd0;
      pend_valid_q <= 1'b0;
      drdy_q       <= 1'b0;
      data_read_q  <= 1'b0;
    end else begin
      if (csn_rise) begin
        if (pend_valid_q) begin
          smp_x_q      <= pend_x_q;
          smp_y_q      <= pend_y_q;
          smp_z_q      <= pend_z_q;
          pend_valid_q <= 1'b0;
          drdy_q       <= 1'b1;
        end else if (data_read_q) begin
          drdy_q <= 1'b0;
        end
        data_read_q <= 1'b0;
      end else if (tx_start && is_sample_addr(addr_q)) begin
        data_read_q <= 1'b1;
      end
      if (sample_accept) begin
        if (csn_lvl) begin
          smp_x_q <= iSAMPLE_X;
          smp_y_q <= iSAMPLE_Y;
          smp_z_q <= iSAMPLE_Z;
          drdy_q  <= 1'b1;
        end else begin
          pend_x_q     <= iSAMPLE_X;
          pend_y_q     <= iSAMPLE_Y;
          pend_z_q     <= iSAMPLE_Z;
          pend_valid_q <= 1'b1;
        end
      end
    end
  end

  assign oSDO       = sdo_q;
  assign oSDO_OE    = (state_q == ST_DATA) && rw_q && !csn_lvl;
  assign oREG_WR    = wr_q;
  assign oREG_ADDR  = wr_addr_q;
  assign oREG_WDATA = wr_data_q;
  assign oMEASURE   = regs_q[POWER_CONTROL][MEASURE_BIT];
  assign oDRDY      = drdy_q & regs_q[INT_ENABLE][DRDY_BIT];

endmodule

// File: tb/tb_adxl_spi_responder.sv
// Directed plus randomized bench for adxl_spi_responder against a transaction-level register model.
`timescale 1ns/1ps
module tb_adxl_spi_responder;

  localparam int HP = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        sclk = 1'b1;
  logic        csn = 1'b1;
  logic        sdi = 1'b0;
  logic        sval = 1'b0;
  logic [15:0] sx = 16'd0, sy = 16'd0, sz = 16'd0;
  logic        sdo, sdo_oe, reg_wr, measure, drdy;
  logic [5:0]  reg_addr;
  logic [7:0]  reg_wdata;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  adxl_spi_responder dut (
    .iRSTN(rstn), .iSPI_CLK(clk), .iSCLK(sclk), .iCSN(csn), .iSDI(sdi),
    .oSDO(sdo), .oSDO_OE(sdo_oe),
    .iSAMPLE_X(sx), .iSAMPLE_Y(sy), .iSAMPLE_Z(sz), .iSAMPLE_VALID(sval),
    .oREG_WR(reg_wr), .oREG_ADDR(reg_addr), .oREG_WDATA(reg_wdata),
    .oMEASURE(measure), .oDRDY(drdy)
  );

  // Reference model state
  logic [7:0]  m_regs [64];
  logic [15:0] m_x, m_y, m_z, p_x, p_y, p_z;
  bit          m_pend, m_drdy, m_rdflag, cs_low_f;
  logic [7:0]  tx_buf [8];
  logic [13:0] wr_log [$];
  logic [13:0] exp_wr [$];
  logic [5:0]  hot [8] = '{6'h2D, 6'h2E, 6'h30, 6'h32, 6'h36, 6'h3F, 6'h1C, 6'h2B};
  logic [7:0]  rx, cmd;
  int          nb, inj;

  always @(negedge clk) if (reg_wr === 1'b1) wr_log.push_back({reg_addr, reg_wdata});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_writable(input logic [5:0] a);
    return (a >= 6'h1D && a <= 6'h2A) || (a >= 6'h2C && a <= 6'h2F) || a == 6'h31 || a == 6'h38;
  endfunction

  function automatic logic [7:0] model_rd(input logic [5:0] a);
    case (a)
      6'h30:   return {m_drdy, 7'b0};
      6'h32:   return m_x[7:0];
      6'h33:   return m_x[15:8];
      6'h34:   return m_y[7:0];
      6'h35:   return m_y[15:8];
      6'h36:   return m_z[7:0];
      6'h37:   return m_z[15:8];
      default: return m_regs[a];
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_regs[i] = 8'h00;
    m_regs[0]     = 8'hE5;
    m_regs[6'h2C] = 8'h0A;
    m_x = 0; m_y = 0; m_z = 0; p_x = 0; p_y = 0; p_z = 0;
    m_pend = 0; m_drdy = 0; m_rdflag = 0; cs_low_f = 0;
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, input int oe_exp, output logic [7:0] r);
    r = 8'h00;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sclk = 1'b0;
      sdi  = tx[7-i];
      repeat (HP-1) @(negedge clk);
      r[7-i] = sdo;
      if (i == 3 && oe_exp >= 0) chk("sdo_oe_in_byte", 32'(sdo_oe), 32'(oe_exp));
      sclk = 1'b1;
      repeat (HP-1) @(negedge clk);
    end
  endtask

  task automatic cs_low();
    @(negedge clk);
    csn = 1'b0;
    cs_low_f = 1;
    repeat (HP) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (HP) @(negedge clk);
    csn = 1'b1;
    cs_low_f = 0;
    if (m_pend) begin
      m_x = p_x; m_y = p_y; m_z = p_z; m_drdy = 1; m_pend = 0;
    end else if (m_rdflag) begin
      m_drdy = 0;
    end
    m_rdflag = 0;
    repeat (HP) @(negedge clk);
  endtask

  task automatic present_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    @(negedge clk);
    sx = x; sy = y; sz = z; sval = 1'b1;
    @(negedge clk);
    sval = 1'b0;
    repeat (2) @(negedge clk);
    if (m_regs[6'h2D][3]) begin
      if (cs_low_f) begin
        p_x = x; p_y = y; p_z = z; m_pend = 1;
      end else begin
        m_x = x; m_y = y; m_z = z; m_drdy = 1;
      end
    end
  endtask

  task automatic check_status(input string tag);
    chk({tag, " measure"}, 32'(measure), 32'(m_regs[6'h2D][3]));
    chk({tag, " drdy"}, 32'(drdy), 32'(m_drdy & m_regs[6'h2E][7]));
    chk({tag, " oe_idle"}, 32'(sdo_oe), 32'd0);
  endtask

  task automatic spi_txn(input logic [7:0] c, input int n, input int inj_at,
                         input logic [15:0] ix, input logic [15:0] iy, input logic [15:0] iz,
                         input string tag);
    logic [7:0] r;
    logic [5:0] a;
    logic [7:0] e;
    wr_log.delete();
    exp_wr.delete();
    cs_low();
    spi_bits(c, 8, 0, r);
    a = c[5:0];
    for (int k = 0; k < n; k++) begin
      if (k == inj_at) present_sample(ix, iy, iz);
      if (c[7]) begin
        e = model_rd(a);
        if (a >= 6'h32 && a <= 6'h37) m_rdflag = 1;
        spi_bits(8'h00, 8, 1, r);
        chk($sformatf("%s rd%0d@%0h", tag, k, a), 32'(r), 32'(e));
      end else begin
        spi_bits(tx_buf[k], 8, 0, r);
        if (m_writable(a)) begin
          m_regs[a] = tx_buf[k];
          exp_wr.push_back({a, tx_buf[k]});
        end
      end
      if (c[6]) a = a + 6'd1;
    end
    cs_high();
    chk({tag, " wr_count"}, 32'(wr_log.size()), 32'(exp_wr.size()));
    if (wr_log.size() == exp_wr.size())
      foreach (exp_wr[i]) chk($sformatf("%s wr%0d", tag, i), 32'(wr_log[i]), 32'(exp_wr[i]));
    check_status(tag);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({sdo, sdo_oe, reg_wr, reg_addr, reg_wdata, measure, drdy}), 32'd0);
    rstn = 1'b1;
    repeat (4) @(negedge clk);

    // 1: enable measurement
    tx_buf[0] = 8'h08;
    spi_txn(8'h2D, 1, -1, 0, 0, 0, "t1");
    chk("t1 measure_on", 32'(measure), 32'd1);
    chk("t1 wr_addr_data", 32'({reg_addr, reg_wdata}), 32'({6'h2D, 8'h08}));

    // 2: DEVID read
    spi_txn(8'h80, 1, -1, 0, 0, 0, "t2");

    // 3: sample, data-ready, burst read
    tx_buf[0] = 8'h80;
    spi_txn(8'h2E, 1, -1, 0, 0, 0, "t3_inten");
    present_sample(16'h0123, 16'hFEDC, 16'h0040);
    chk("t3 drdy_set", 32'(drdy), 32'd1);
    spi_txn(8'hF2, 6, -1, 0, 0, 0, "t3_burst");
    chk("t3 drdy_clear", 32'(drdy), 32'd0);

    // 4: sample arrives mid-read, stays pending until CSN rise
    spi_txn(8'hF2, 6, 3, 16'h7FFF, 16'h1234, 16'h8001, "t4_first");
    chk("t4 drdy_kept", 32'(drdy), 32'd1);
    spi_txn(8'hF2, 6, -1, 0, 0, 0, "t4_second");

    // 5: dropped write, multi-byte write with a dropped tail
    tx_buf[0] = 8'h55;
    spi_txn(8'h00, 1, -1, 0, 0, 0, "t5_devid_wr");
    spi_txn(8'h80, 1, -1, 0, 0, 0, "t5_devid_rd");
    tx_buf[0] = 8'h11; tx_buf[1] = 8'h22; tx_buf[2] = 8'h33;
    spi_txn(8'h6E, 3, -1, 0, 0, 0, "t5_mb_wr");
    spi_txn(8'hEE, 3, -1, 0, 0, 0, "t5_mb_rd");

    // 6a: abort a write after 4 data bits
    wr_log.delete();
    cs_low();
    spi_bits(8'h31, 8, 0, rx);
    spi_bits(8'hAB, 4, 0, rx);
    cs_high();
    chk("t6 abort_no_wr", 32'(wr_log.size()), 32'd0);
    chk("t6 abort_oe", 32'(sdo_oe), 32'd0);
    spi_txn(8'hB1, 1, -1, 0, 0, 0, "t6_reg31");

    // 6b: reset in the middle of a read
    cs_low();
    spi_bits(8'hB2, 8, 0, rx);
    spi_bits(8'h00, 3, 1, rx);
    chk("t6 oe_before_rst", 32'(sdo_oe), 32'd1);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("t6 rst_outputs", 32'({sdo, sdo_oe, reg_wr, reg_addr, reg_wdata, measure, drdy}), 32'd0);
    csn = 1'b1; sclk = 1'b1; sdi = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    spi_txn(8'hAC, 1, -1, 0, 0, 0, "t6_bwrate");

    // Randomized traffic against the model
    tx_buf[0] = 8'h08; tx_buf[1] = 8'h80;
    spi_txn(8'h6D, 2, -1, 0, 0, 0, "rnd_setup");
    for (int t = 0; t < 30; t++) begin
      cmd = 8'($urandom);
      if ($urandom_range(0, 1) == 1) cmd[5:0] = hot[$urandom_range(0, 7)];
      nb = $urandom_range(1, 4);
      for (int k = 0; k < 8; k++) tx_buf[k] = 8'($urandom);
      if ($urandom_range(0, 2) == 0)
        present_sample(16'($urandom), 16'($urandom), 16'($urandom));
      inj = ($urandom_range(0, 2) == 0) ? $urandom_range(0, nb - 1) : -1;
      spi_txn(cmd, nb, inj, 16'($urandom), 16'($urandom), 16'($urandom), $sformatf("rnd%0d", t));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
